// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path.
//   frame_state_e : frame decoder state encoding
//   SYNC_BYTE     : default frame start marker
//   CLKS_PER_BIT  : clocks per UART bit, shared with the receiver
//   xor_fold      : running XOR checksum step
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LEN     = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    HOLD    = 3'd4
  } frame_state_e;

  localparam logic [7:0] SYNC_BYTE    = 8'hA5;
  localparam int         CLKS_PER_BIT = 217;

  // Fold one byte into the running XOR checksum.
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] data);
    return acc ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// uart_frame_buf: p_DEPTH x 8 payload store with one write port and a
// registered read port. The array itself is not reset; only the read
// register is.
//   i_Clk, i_Rst_n        : clock, async active-low reset
//   i_Wr_En/Idx/Data      : write port
//   i_Rd_Addr, o_Rd_Data  : read address, data one cycle later
module uart_frame_buf #(
  parameter int p_DEPTH = 16
) (
  input  logic                       i_Clk,
  input  logic                       i_Rst_n,
  input  logic                       i_Wr_En,
  input  logic [$clog2(p_DEPTH)-1:0] i_Wr_Idx,
  input  logic [7:0]                 i_Wr_Data,
  input  logic [$clog2(p_DEPTH)-1:0] i_Rd_Addr,
  output logic [7:0]                 o_Rd_Data
);

  logic [7:0] mem_r [p_DEPTH];
  logic [7:0] rd_data_r;

  // Payload storage write.
  always_ff @(posedge i_Clk) begin
    if (i_Wr_En) begin
      mem_r[i_Wr_Idx] <= i_Wr_Data;
    end
  end

  // Registered read port.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rd_data_r <= 8'h00;
    end else begin
      rd_data_r <= mem_r[i_Rd_Addr];
    end
  end

  assign o_Rd_Data = rd_data_r;

endmodule

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for a sync byte in the receiver's byte stream,
// assembles SYNC/LEN/payload[/CHK] frames into a payload buffer and holds
// each complete frame for the consumer until acknowledged.
// Build option: define FRAME_CHECKSUM_EN to require a trailing CHK byte
// (XOR of LEN and payload); otherwise o_Err_Checksum is tied to 0.
//   i_Clk, i_Rst_n                  : clock, async active-low reset
//   i_Rx_ByteCompleted, i_Rx_Byte   : byte strobe and byte from receiver
//   o_Frame_Valid, o_Frame_Len      : held frame present and its length
//   i_Frame_Ack                     : consumer releases the held frame
//   i_Rd_Addr, o_Rd_Data            : payload read (one cycle latency)
//   o_Err_Len/Checksum/Timeout/Overrun : single-cycle error pulses
// LEN is taken from the low bits of the LEN byte, so p_MAX_LEN <= 128.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int         p_MAX_LEN      = 16,
  parameter logic [7:0] p_SYNC_BYTE    = SYNC_BYTE,
  parameter int         p_TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic                         i_Clk,
  input  logic                         i_Rst_n,
  input  logic                         i_Rx_ByteCompleted,
  input  logic [7:0]                   i_Rx_Byte,
  output logic                         o_Frame_Valid,
  output logic [$clog2(p_MAX_LEN):0]   o_Frame_Len,
  input  logic                         i_Frame_Ack,
  input  logic [$clog2(p_MAX_LEN)-1:0] i_Rd_Addr,
  output logic [7:0]                   o_Rd_Data,
  output logic                         o_Err_Len,
  output logic                         o_Err_Checksum,
  output logic                         o_Err_Timeout,
  output logic                         o_Err_Overrun
);

  localparam int AW = $clog2(p_MAX_LEN);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(p_TIMEOUT_CLKS);

  frame_state_e state_r, next_state_s;

  logic [LW-1:0] len_r;
  logic [AW-1:0] idx_r;
  logic [TW-1:0] tmo_cnt_r;

  logic strobe_s, in_frame_s, len_ok_s, last_byte_s, timeout_s;
  logic wr_en_s, err_len_s, err_chk_s, err_to_s, err_ovr_s;

  logic          frame_valid_r;
  logic [LW-1:0] frame_len_r;
  logic          err_len_r, err_chk_r, err_to_r, err_ovr_r;

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] xor_r;
  logic       chk_ok_s;
  assign chk_ok_s = (i_Rx_Byte == xor_r);
`endif

  assign strobe_s    = i_Rx_ByteCompleted;
  assign in_frame_s  = (state_r == LEN) || (state_r == PAYLOAD) || (state_r == CHECK);
  assign len_ok_s    = (i_Rx_Byte != 8'h00) && ({1'b0, i_Rx_Byte} <= 9'(p_MAX_LEN));
  assign last_byte_s = ((LW'(idx_r) + LW'(1'b1)) == len_r);
  // A strobe in the same cycle as expiry wins over the timeout.
  assign timeout_s   = in_frame_s && !strobe_s && (tmo_cnt_r == TW'(p_TIMEOUT_CLKS - 1));

  // State register.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (strobe_s && (i_Rx_Byte == p_SYNC_BYTE)) next_state_s = LEN;
        else                                        next_state_s = IDLE;
      end
      LEN: begin
        if (strobe_s)       next_state_s = len_ok_s ? PAYLOAD : IDLE;
        else if (timeout_s) next_state_s = IDLE;
        else                next_state_s = LEN;
      end
      PAYLOAD: begin
        if (strobe_s && last_byte_s) begin
`ifdef FRAME_CHECKSUM_EN
          next_state_s = CHECK;
`else
          next_state_s = HOLD;
`endif
        end else if (timeout_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = PAYLOAD;
        end
      end
      CHECK: begin
`ifdef FRAME_CHECKSUM_EN
        if (strobe_s)       next_state_s = chk_ok_s ? HOLD : IDLE;
        else if (timeout_s) next_state_s = IDLE;
        else                next_state_s = CHECK;
`else
        next_state_s = IDLE;
`endif
      end
      // Ack releases the frame even when an overrun byte arrives alongside it;
      // that byte is discarded, never taken as SYNC.
      HOLD: begin
        if (i_Frame_Ack) next_state_s = IDLE;
        else             next_state_s = HOLD;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // Per-state write enable and error conditions.
  always_comb begin
    wr_en_s   = 1'b0;
    err_len_s = 1'b0;
    err_chk_s = 1'b0;
    err_to_s  = 1'b0;
    err_ovr_s = 1'b0;
    case (state_r)
      IDLE: begin
        wr_en_s = 1'b0;
      end
      LEN: begin
        err_len_s = strobe_s && !len_ok_s;
        err_to_s  = timeout_s;
      end
      PAYLOAD: begin
        wr_en_s  = strobe_s;
        err_to_s = timeout_s;
      end
      CHECK: begin
`ifdef FRAME_CHECKSUM_EN
        err_chk_s = strobe_s && !chk_ok_s;
        err_to_s  = timeout_s;
`else
        err_chk_s = 1'b0;
`endif
      end
      HOLD: begin
        err_ovr_s = strobe_s;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Frame length, write index, checksum and inter-byte timeout counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      len_r     <= {LW{1'b0}};
      idx_r     <= {AW{1'b0}};
      tmo_cnt_r <= {TW{1'b0}};
`ifdef FRAME_CHECKSUM_EN
      xor_r     <= 8'h00;
`endif
    end else begin
      if ((state_r == LEN) && strobe_s && len_ok_s) begin
        len_r <= i_Rx_Byte[LW-1:0];
        idx_r <= {AW{1'b0}};
`ifdef FRAME_CHECKSUM_EN
        // Cleared XOR folded with LEN is just LEN.
        xor_r <= i_Rx_Byte;
`endif
      end else if (wr_en_s) begin
        idx_r <= idx_r + AW'(1'b1);
`ifdef FRAME_CHECKSUM_EN
        xor_r <= xor_fold(xor_r, i_Rx_Byte);
`endif
      end
      if (!in_frame_s || strobe_s || timeout_s) begin
        tmo_cnt_r <= {TW{1'b0}};
      end else begin
        tmo_cnt_r <= tmo_cnt_r + TW'(1'b1);
      end
    end
  end

  // Registered outputs; error pulses appear the cycle after their cause.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      frame_valid_r <= 1'b0;
      frame_len_r   <= {LW{1'b0}};
      err_len_r     <= 1'b0;
      err_chk_r     <= 1'b0;
      err_to_r      <= 1'b0;
      err_ovr_r     <= 1'b0;
    end else begin
      frame_valid_r <= (next_state_s == HOLD);
      frame_len_r   <= (next_state_s == HOLD) ? len_r : {LW{1'b0}};
      err_len_r     <= err_len_s;
      err_chk_r     <= err_chk_s;
      err_to_r      <= err_to_s;
      err_ovr_r     <= err_ovr_s;
    end
  end

  uart_frame_buf #(
    .p_DEPTH (p_MAX_LEN)
  ) u_buf (
    .i_Clk     (i_Clk),
    .i_Rst_n   (i_Rst_n),
    .i_Wr_En   (wr_en_s),
    .i_Wr_Idx  (idx_r),
    .i_Wr_Data (i_Rx_Byte),
    .i_Rd_Addr (i_Rd_Addr),
    .o_Rd_Data (o_Rd_Data)
  );

  assign o_Frame_Valid  = frame_valid_r;
  assign o_Frame_Len    = frame_len_r;
  assign o_Err_Len      = err_len_r;
  assign o_Err_Checksum = err_chk_r;
  assign o_Err_Timeout  = err_to_r;
  assign o_Err_Overrun  = err_ovr_r;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Scoreboard bench for uart_frame_decoder (default parameters). Works with
// or without FRAME_CHECKSUM_EN defined.
module tb_uart_frame_decoder;

  localparam int TMO = 4340;

  localparam logic [4:0] EV_VALID = 5'b10000;
  localparam logic [4:0] EV_LEN   = 5'b01000;
  localparam logic [4:0] EV_CHK   = 5'b00100;
  localparam logic [4:0] EV_TO    = 5'b00010;
  localparam logic [4:0] EV_OVR   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe;
  logic [7:0] rx_byte;
  logic       valid;
  logic [4:0] flen;
  logic       ack;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       e_len, e_chk, e_to, e_ovr;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_ev_q [$];
  logic [7:0] exp_rd_q [$];
  logic       rd_req = 1'b0;
  logic       rd_req_d = 1'b0;
  logic       prev_valid = 1'b0;
  logic [7:0] tx_buf [32];

  always #5 clk = ~clk;

  uart_frame_decoder dut (
    .i_Clk              (clk),
    .i_Rst_n            (rst_n),
    .i_Rx_ByteCompleted (strobe),
    .i_Rx_Byte          (rx_byte),
    .o_Frame_Valid      (valid),
    .o_Frame_Len        (flen),
    .i_Frame_Ack        (ack),
    .i_Rd_Addr          (rd_addr),
    .o_Rd_Data          (rd_data),
    .o_Err_Len          (e_len),
    .o_Err_Checksum     (e_chk),
    .o_Err_Timeout      (e_to),
    .o_Err_Overrun      (e_ovr)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  always @(posedge clk) rd_req_d <= rd_req;

  // Monitor: every output event or read result is popped and compared.
  always @(negedge clk) begin
    logic [4:0] ev;
    logic [9:0] got;
    ev = {valid && !prev_valid, e_len, e_chk, e_to, e_ovr};
    prev_valid = valid;
    if (ev != 5'd0) begin
      got = {ev, ev[4] ? flen : 5'd0};
      if (exp_ev_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got %b expected none", got);
      end else begin
        check("event", 32'(got), 32'(exp_ev_q.pop_front()));
      end
    end
    if (rd_req_d) begin
      if (exp_rd_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_read: got %h expected none", rd_data);
      end else begin
        check("rd_data", 32'(rd_data), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    strobe  = 1'b1;
    @(negedge clk);
    strobe  = 1'b0;
  endtask

  // SYNC, LEN, tx_buf[0..n-1] and, when enabled, CHK (or a wrong CHK).
  task automatic send_frame(input int n, input logic [7:0] len_b, input logic bad_chk);
    logic [7:0] chk;
    chk = len_b;
    send_byte(8'hA5);
    send_byte(len_b);
    for (int i = 0; i < n; i++) begin
      chk = chk ^ tx_buf[i];
      send_byte(tx_buf[i]);
    end
`ifdef FRAME_CHECKSUM_EN
    send_byte(bad_chk ? 8'hFF : chk);
`else
    if (bad_chk) $display("note: wrong CHK requested without checksum build");
`endif
  endtask

  task automatic do_read(input logic [3:0] a, input logic [7:0] want);
    @(negedge clk);
    rd_addr = a;
    rd_req  = 1'b1;
    exp_rd_q.push_back(want);
    @(negedge clk);
    rd_req  = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_len"},   32'(flen), 32'd0);
    check({tag, "_rd"},    32'(rd_data), 32'd0);
    check({tag, "_errs"},  32'({e_len, e_chk, e_to, e_ovr}), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; strobe = 1'b0; rx_byte = 8'h00; ack = 1'b0; rd_addr = 4'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frame, length 3, then read back and release.
    tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33;
    exp_ev_q.push_back({EV_VALID, 5'd3});
    send_frame(3, 8'h03, 1'b0);
    check("t1_valid_rise", 32'(valid), 32'd1);
    check("t1_len", 32'(flen), 32'd3);
    do_read(4'd0, 8'h11);
    do_read(4'd1, 8'h22);
    do_read(4'd2, 8'h33);
    check("t1_valid_held", 32'(valid), 32'd1);
    do_ack();
    check("t1_valid_drop", 32'(valid), 32'd0);

`ifdef FRAME_CHECKSUM_EN
    // Wrong checksum is dropped; a correct frame follows.
    exp_ev_q.push_back({EV_CHK, 5'd0});
    send_frame(3, 8'h03, 1'b1);
    check("t2_no_valid", 32'(valid), 32'd0);
    exp_ev_q.push_back({EV_VALID, 5'd3});
    send_frame(3, 8'h03, 1'b0);
    do_read(4'd1, 8'h22);
    do_ack();
`endif

    // Length 0 and length p_MAX_LEN+1.
    exp_ev_q.push_back({EV_LEN, 5'd0});
    exp_ev_q.push_back({EV_LEN, 5'd0});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h11);
    repeat (3) @(negedge clk);
    check("t3_len_errs_seen", 32'(exp_ev_q.size()), 32'd0);
    check("t3_no_valid", 32'(valid), 32'd0);

    // Stalled frame times out; next frame decodes.
    exp_ev_q.push_back({EV_TO, 5'd0});
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h11);
    repeat (TMO + 20) @(negedge clk);
    check("t4_timeout_seen", 32'(exp_ev_q.size()), 32'd0);
    tx_buf[0] = 8'h7E;
    exp_ev_q.push_back({EV_VALID, 5'd1});
    send_frame(1, 8'h01, 1'b0);
    check("t4_len", 32'(flen), 32'd1);
    do_read(4'd0, 8'h7E);
    do_ack();

    // Overrun with simultaneous ack: byte dropped, not taken as SYNC.
    tx_buf[0] = 8'h55;
    exp_ev_q.push_back({EV_VALID, 5'd1});
    send_frame(1, 8'h01, 1'b0);
    exp_ev_q.push_back({EV_OVR, 5'd0});
    @(negedge clk);
    rx_byte = 8'hA5; strobe = 1'b1; ack = 1'b1;
    @(negedge clk);
    strobe = 1'b0; ack = 1'b0;
    check("t5_valid_drop", 32'(valid), 32'd0);
    send_byte(8'h02);
    exp_ev_q.push_back({EV_VALID, 5'd1});
    send_frame(1, 8'h01, 1'b0);
    do_read(4'd0, 8'h55);
    do_ack();

    // Maximum length frame.
    for (int i = 0; i < 16; i++) tx_buf[i] = 8'hC0 + 8'(i);
    exp_ev_q.push_back({EV_VALID, 5'd16});
    send_frame(16, 8'h10, 1'b0);
    check("t6_len", 32'(flen), 32'd16);
    do_read(4'd0, 8'hC0);
    do_read(4'd15, 8'hCF);
    do_ack();

    // Reset mid-payload aborts silently; a full frame then decodes.
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("t7_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tx_buf[0] = 8'hAA; tx_buf[1] = 8'hBB;
    exp_ev_q.push_back({EV_VALID, 5'd2});
    send_frame(2, 8'h02, 1'b0);
    check("t7_valid_next_cycle", 32'(valid), 32'd1);
    check("t7_len", 32'(flen), 32'd2);
    do_read(4'd0, 8'hAA);
    do_read(4'd1, 8'hBB);
    do_ack();
    check("t7_valid_drop", 32'(valid), 32'd0);

    repeat (10) @(negedge clk);
    check("final_events_drained", 32'(exp_ev_q.size()), 32'd0);
    check("final_reads_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
